// File: rtl/binary_add_pipe.sv
// binary_add_pipe
// Pipelined add/subtract unit with valid/ready handshaking. The carry chain is
// cut into STAGES segments of ceil(WIDTH/STAGES) bits, LSB first; stage k
// resolves segment k using the carry registered by stage k-1. The remaining
// operand bits and op travel with each transfer so every slot stays aligned.
//
// Parameters:
//   WIDTH  (2..64)     operand / result width
//   STAGES (1..WIDTH)  number of register stages (= latency in cycles)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   A, B       operands
//   op         0 = A+B, 1 = A-B (computed as A + ~B + 1)
//   in_valid   operand set valid
//   in_ready   pipeline can advance this cycle
//   S          result (wrapped, or saturated when enabled)
//   cout       raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf        two's-complement overflow of the raw result
//   out_valid  S/cout/ovf valid
//   out_ready  downstream accepts the result
//
// Configuration:
//   BINARY_ADD_SAT_EN  when defined, S saturates to all-ones on an add that
//                      carries out and to zero on a subtract that borrows.
//                      cout and ovf always describe the raw result.

module binary_add_pipe #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    logic adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Bit range owned by this stage; may be empty for trailing stages
        // when WIDTH does not divide evenly.
        localparam int LO      = k * SEG;
        localparam int HI      = (((k + 1) * SEG) > WIDTH) ? WIDTH : ((k + 1) * SEG);
        localparam bit IS_LAST = (k == STAGES - 1);

        logic [WIDTH-1:0] a_in_s;
        logic [WIDTH-1:0] b_in_s;
        logic [WIDTH-1:0] s_in_s;
        logic             c_in_s;
        logic             cm_in_s;
        logic             op_in_s;
        logic             v_in_s;

        logic [WIDTH-1:0] s_nx_s;
        logic [WIDTH-1:0] s_out_s;
        logic             c_nx_s;
        logic             cm_nx_s;

        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] b_r;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             cm_r;
        logic             ovf_r;
        logic             op_r;
        logic             v_r;

        if (k == 0) begin : g_head
            // B is inverted up front for subtract; op doubles as the carry-in.
            assign a_in_s  = A;
            assign b_in_s  = op ? ~B : B;
            assign s_in_s  = '0;
            assign c_in_s  = op;
            assign cm_in_s = 1'b0;
            assign op_in_s = op;
            assign v_in_s  = in_valid;
        end else begin : g_body
            assign a_in_s  = g_stage[k-1].a_r;
            assign b_in_s  = g_stage[k-1].b_r;
            assign s_in_s  = g_stage[k-1].s_r;
            assign c_in_s  = g_stage[k-1].c_r;
            assign cm_in_s = g_stage[k-1].cm_r;
            assign op_in_s = g_stage[k-1].op_r;
            assign v_in_s  = g_stage[k-1].v_r;
        end

        // Ripple this stage's segment; bits outside it pass through unchanged.
        always_comb begin
            s_nx_s  = s_in_s;
            c_nx_s  = c_in_s;
            cm_nx_s = cm_in_s;
            for (int i = 0; i < WIDTH; i++) begin
                if ((i >= LO) && (i < HI)) begin
                    s_nx_s[i] = a_in_s[i] ^ b_in_s[i] ^ c_nx_s;
                    // Remember the carry entering the MSB for overflow.
                    cm_nx_s   = (i == WIDTH - 1) ? c_nx_s : cm_nx_s;
                    c_nx_s    = (a_in_s[i] & b_in_s[i]) | (c_nx_s & (a_in_s[i] ^ b_in_s[i]));
                end else begin
                    s_nx_s[i] = s_in_s[i];
                end
            end
        end

`ifdef BINARY_ADD_SAT_EN
        // Final stage clamps the unsigned result; earlier stages pass through.
        always_comb begin
            s_out_s = s_nx_s;
            if (IS_LAST && !op_in_s && c_nx_s) begin
                s_out_s = '1;
            end else if (IS_LAST && op_in_s && !c_nx_s) begin
                s_out_s = '0;
            end else begin
                s_out_s = s_nx_s;
            end
        end
`else
        assign s_out_s = s_nx_s;
`endif

        // Stage registers: load on advance, hold otherwise, clear on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_r   <= '0;
                b_r   <= '0;
                s_r   <= '0;
                c_r   <= 1'b0;
                cm_r  <= 1'b0;
                ovf_r <= 1'b0;
                op_r  <= 1'b0;
                v_r   <= 1'b0;
            end else if (adv_s) begin
                a_r   <= a_in_s;
                b_r   <= b_in_s;
                s_r   <= s_out_s;
                c_r   <= c_nx_s;
                cm_r  <= cm_nx_s;
                ovf_r <= cm_nx_s ^ c_nx_s;
                op_r  <= op_in_s;
                v_r   <= v_in_s;
            end else begin
                a_r   <= a_r;
                b_r   <= b_r;
                s_r   <= s_r;
                c_r   <= c_r;
                cm_r  <= cm_r;
                ovf_r <= ovf_r;
                op_r  <= op_r;
                v_r   <= v_r;
            end
        end
    end

    // The whole pipeline moves together whenever the output slot can drain.
    assign adv_s     = out_ready | ~g_stage[STAGES-1].v_r;
    assign in_ready  = adv_s;

    assign S         = g_stage[STAGES-1].s_r;
    assign cout      = g_stage[STAGES-1].c_r;
    assign ovf       = g_stage[STAGES-1].ovf_r;
    assign out_valid = g_stage[STAGES-1].v_r;

endmodule

// File: doc/binary_add_pipe.md
BINARY_ADD_PIPE -- requirements
Module: binary_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 11: operand and sum width in bits, range 2..64.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline register stages, range 1..WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port A  input  WIDTH  first operand.
REQ-006 SHALL have port B  input  WIDTH  second operand.
REQ-007 SHALL have port op  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-008 SHALL have port in_valid  input  1  A/B/op valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts an operand set this cycle.
REQ-010 SHALL have port S  output  WIDTH  result.
REQ-011 SHALL have port cout  output  1  raw carry out of the MSB (for subtract, 1 = no borrow).
REQ-012 SHALL have port ovf  output  1  two's-complement signed overflow of the raw result.
REQ-013 SHALL have port out_valid  output  1  S/cout/ovf hold a valid result.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-015 SHALL compute the raw result as A + B + 0 when op=0 and as A + ~B + 1 when op=1, modulo 2^WIDTH.
REQ-016 SHALL split the carry chain into STAGES segments of ceil(WIDTH/STAGES) bits from the LSB, with the last segment taking the remainder.
REQ-017 SHALL compute segment k in stage k, using the registered carry from stage k-1; the stage-0 carry-in SHALL be op.
REQ-018 SHALL register the not-yet-used operand bits and op alongside each stage so that each transfer's bits stay aligned.
REQ-019 SHALL use the pipeline advance condition adv = out_ready OR NOT out_valid; all stage registers load on adv and hold otherwise.
REQ-020 SHALL drive in_ready = adv, combinationally.
REQ-021 SHALL accept a transfer when in_valid AND in_ready are both 1; a stage-0 valid bit SHALL capture in_valid on adv.
REQ-022 SHALL set the latency from acceptance to out_valid to exactly STAGES cycles when out_ready stays 1.
REQ-023 SHALL sustain a throughput of one result per cycle when in_valid and out_ready are both held at 1.
REQ-024 SHALL hold S, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL deliver results in acceptance order with no loss or duplication; bubbles propagate as invalid slots.
REQ-026 SHALL compute ovf as carry-into-MSB XOR carry-out-of-MSB of the raw result.

Reset
REQ-027 SHALL, while rst=1, force every stage valid bit, out_valid, S, cout and ovf to 0 immediately, regardless of clk.
REQ-028 SHALL discard all in-flight transfers when rst asserts mid-operation; after rst deasserts, in_ready SHALL be 1 and the first result SHALL appear STAGES cycles after the first accepted transfer.

Configuration
REQ-029 SHALL compile the unsigned saturation feature in only when macro BINARY_ADD_SAT_EN is defined.
REQ-030 SHALL, with BINARY_ADD_SAT_EN defined, force S to all-ones on add with cout=1 and to all-zeros on subtract with cout=0; cout and ovf still report the raw result.
REQ-031 SHALL, without BINARY_ADD_SAT_EN, output the wrapped raw result on S, with no saturation logic present.

Verification (WIDTH=11, STAGES=2)
REQ-032 SHALL cover: add A=2047, B=1 with out_ready=1 -> 2 cycles later S=0, cout=1, ovf=0; with the macro defined, S=2047.
REQ-033 SHALL cover: add A=1023, B=1 -> S=1024, cout=0, ovf=1.
REQ-034 SHALL cover: subtract A=5, B=7 -> S=2046, cout=0, ovf=0; with the macro defined, S=0.
REQ-035 SHALL cover: stream 8 random transfers while out_ready toggles in a 3-low/2-high pattern -> in_ready=0 whenever out_valid=1 and out_ready=0, outputs stable while stalled, all 8 results correct and in order.
REQ-036 SHALL cover: assert rst for 1 cycle with 2 transfers in flight -> out_valid=0 at once, no stale result emitted; the next transfer A=3, B=4 (add) yields S=7 after 2 cycles.
REQ-037 SHALL cover: back-to-back transfers with STAGES=1 and STAGES=11 -> one result per cycle, latency 1 and 11 respectively.
